// File: rtl/regfile_mp.sv
// Multi-port integer register file with a long-latency scoreboard; r0 reads as zero.
// Optional write-first forwarding to the read ports is enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic                   wr0_en,
    input  logic [AW-1:0]          wr0_addr,
    input  logic [XLEN-1:0]        wr0_data,
    input  logic                   wr1_en,
    input  logic [AW-1:0]          wr1_addr,
    input  logic [XLEN-1:0]        wr1_data,
    input  logic                   sb_set,
    input  logic [AW-1:0]          sb_addr,
    output logic                   sb_any
);

    // Entry 0 has no storage at all; reads of address 0 fall through to zero.
    logic [XLEN-1:0]  mem [1:NREGS-1];
    logic [NREGS-1:1] sb;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                mem[i] <= '0;
            end
            sb <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                // Port 0 wins a data collision; the port 1 clear still applies below.
                if (wr0_en && wr0_addr == AW'(i)) begin
                    mem[i] <= wr0_data;
                end else if (wr1_en && wr1_addr == AW'(i)) begin
                    mem[i] <= wr1_data;
                end
                // A set belongs to a younger op than the completing one, so it wins.
                if (sb_set && sb_addr == AW'(i)) begin
                    sb[i] <= 1'b1;
                end else if (wr1_en && wr1_addr == AW'(i)) begin
                    sb[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin : read_ports
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            b;
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            a = rd_addr[k*AW +: AW];
            d = '0;
            b = 1'b0;
            for (int i = 1; i < NREGS; i++) begin
                if (a == AW'(i)) begin
                    d = mem[i];
                    b = sb[i];
                end
            end
`ifdef REGFILE_MP_BYPASS_EN
            if (a != '0) begin
                if (wr1_en && wr1_addr == a) begin
                    d = wr1_data;
                    if (!(sb_set && sb_addr == a)) begin
                        b = 1'b0;
                    end
                end
                if (wr0_en && wr0_addr == a) begin
                    d = wr0_data;
                end
            end
`endif
            if (rst) begin
                d = '0;
                b = 1'b0;
            end
            rd_data[k*XLEN +: XLEN] = d;
            rd_busy[k]              = b;
        end
    end

    assign sb_any = rst ? 1'b0 : |sb;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp (XLEN=64, NUM_RD=4): directed test-plan steps then random traffic,
// every cycle compared against an array-based reference model of the register file.
module tb_regfile_mp;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NR    = 4;

    logic                 clk;
    logic                 rst;
    logic [NR*AW-1:0]     rd_addr;
    logic [NR*XLEN-1:0]   rd_data;
    logic [NR-1:0]        rd_busy;
    logic                 wr0_en;
    logic [AW-1:0]        wr0_addr;
    logic [XLEN-1:0]      wr0_data;
    logic                 wr1_en;
    logic [AW-1:0]        wr1_addr;
    logic [XLEN-1:0]      wr1_data;
    logic                 sb_set;
    logic [AW-1:0]        sb_addr;
    logic                 sb_any;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NUM_RD(NR)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .sb_any   (sb_any)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [XLEN-1:0] model_mem [NREGS];
    logic            model_sb  [NREGS];
    logic [XLEN-1:0] exp_q [$];
    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_bypass();
`ifdef REGFILE_MP_BYPASS_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Compare every output against what the model says it should be right now.
    task automatic check_all();
        logic [AW-1:0] a;
        logic [XLEN-1:0] ed;
        logic eb;
        logic any;
        for (int k = 0; k < NR; k++) begin
            a  = rd_addr[k*AW +: AW];
            ed = 0;
            eb = 1'b0;
            if (!rst && a != 0) begin
                ed = model_mem[a];
                eb = model_sb[a];
                if (model_bypass()) begin
                    if (wr0_en && wr0_addr == a)      ed = wr0_data;
                    else if (wr1_en && wr1_addr == a) ed = wr1_data;
                    if (wr1_en && wr1_addr == a && !(sb_set && sb_addr == a)) eb = 1'b0;
                end
            end
            exp_q.push_back(ed);
            exp_q.push_back({{(XLEN-1){1'b0}}, eb});
            chk($sformatf("rd_data[%0d] a=%0d", k, a), rd_data[k*XLEN +: XLEN], exp_q.pop_front());
            chk($sformatf("rd_busy[%0d] a=%0d", k, a), {{(XLEN-1){1'b0}}, rd_busy[k]}, exp_q.pop_front());
        end
        any = 1'b0;
        for (int i = 1; i < NREGS; i++) any |= model_sb[i];
        if (rst) any = 1'b0;
        chk("sb_any", {{(XLEN-1){1'b0}}, sb_any}, {{(XLEN-1){1'b0}}, any});
    endtask

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                model_mem[i] = 0;
                model_sb[i]  = 1'b0;
            end
        end else begin
            if (wr1_en && wr1_addr != 0) begin
                model_mem[wr1_addr] = wr1_data;
                model_sb[wr1_addr]  = 1'b0;
            end
            if (wr0_en && wr0_addr != 0) model_mem[wr0_addr] = wr0_data;
            if (sb_set && sb_addr != 0)  model_sb[sb_addr] = 1'b1;
        end
    endtask

    // driver tasks
    task automatic tick();
        #2;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wr0_en = 0; wr0_addr = 0; wr0_data = 0;
        wr1_en = 0; wr1_addr = 0; wr1_data = 0;
        sb_set = 0; sb_addr  = 0;
    endtask

    task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
        rd_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endtask

    task automatic wr0(input int a, input logic [XLEN-1:0] d);
        wr0_en = 1; wr0_addr = AW'(a); wr0_data = d;
    endtask

    task automatic wr1(input int a, input logic [XLEN-1:0] d);
        wr1_en = 1; wr1_addr = AW'(a); wr1_data = d;
    endtask

    task automatic sbs(input int a);
        sb_set = 1; sb_addr = AW'(a);
    endtask

    function automatic logic [XLEN-1:0] port_data(input int k);
        return rd_data[k*XLEN +: XLEN];
    endfunction

    initial begin
        for (int i = 0; i < NREGS; i++) begin
            model_mem[i] = 0;
            model_sb[i]  = 1'b0;
        end
        idle();
        set_rd(0, 0, 0, 0);
        rst = 1;
        @(posedge clk); #1;
        tick(); tick();
        rst = 0;
        tick();

        // reset clears a written register and the scoreboard
        wr0(5, 64'hDEADBEEF); sbs(5); set_rd(5, 5, 0, 1);
        tick();
        idle();
        tick();
        chk("r5 before reset", port_data(0), 64'hDEADBEEF);
        rst = 1; wr0(6, 64'h1); sbs(6);
        tick(); tick();
        idle(); rst = 0; set_rd(5, 6, 5, 6);
        tick();
        chk("r5 after reset", port_data(0), 64'h0);
        chk("r6 after reset", port_data(1), 64'h0);
        chk("sb_any after reset", {63'b0, sb_any}, 64'h0);
        chk("rd_busy after reset", {60'b0, rd_busy}, 64'h0);

        // r0 is hardwired
        wr0(0, 64'h12345678); sbs(0);
        tick();
        idle(); set_rd(0, 0, 0, 0);
        tick();
        chk("r0 data", port_data(2), 64'h0);
        chk("r0 busy", {60'b0, rd_busy}, 64'h0);

        // collision: port 0 data kept, port 1 clear still applies
        sbs(7);
        tick();
        idle(); wr0(7, 64'hAAAA0000); wr1(7, 64'h5555FFFF); set_rd(1, 2, 3, 7);
        tick();
        idle();
        tick();
        chk("collision data", port_data(3), 64'hAAAA0000);
        chk("collision busy", {63'b0, rd_busy[3]}, 64'h0);

        // scoreboard lifecycle on r9
        sbs(9); set_rd(9, 9, 9, 9);
        tick();
        idle();
        tick();
        chk("r9 busy after set", {63'b0, rd_busy[0]}, 64'h1);
        chk("sb_any after set", {63'b0, sb_any}, 64'h1);
        wr1(9, 64'h42);
        tick();
        idle();
        tick();
        chk("r9 busy after wr1", {63'b0, rd_busy[1]}, 64'h0);
        chk("r9 data after wr1", port_data(1), 64'h42);
        sbs(9); wr1(9, 64'h43);
        tick();
        idle();
        tick();
        chk("r9 busy set+clear", {63'b0, rd_busy[2]}, 64'h1);
        wr1(9, 64'h44);
        tick();
        idle();

        // same-cycle read of a register being written
        wr0(3, 64'h1111); set_rd(0, 3, 0, 0);
        tick();
        idle();
        tick();
        wr0(3, 64'hCAFEF00D);
        #2;
        chk("bypass same cycle", port_data(1), model_bypass() ? 64'hCAFEF00D : 64'h1111);
        tick();
        idle();
        tick();
        chk("r3 next cycle", port_data(1), 64'hCAFEF00D);

        // four ports, four distinct 64-bit patterns
        wr0(10, 64'h0123456789ABCDEF); wr1(11, 64'hFEDCBA9876543210);
        tick();
        idle(); wr0(12, 64'hA5A5A5A55A5A5A5A); wr1(13, 64'h8000000000000001);
        tick();
        idle(); set_rd(10, 11, 12, 13);
        tick();
        chk("port0 r10", port_data(0), 64'h0123456789ABCDEF);
        chk("port1 r11", port_data(1), 64'hFEDCBA9876543210);
        chk("port2 r12", port_data(2), 64'hA5A5A5A55A5A5A5A);
        chk("port3 r13", port_data(3), 64'h8000000000000001);

        // random traffic, small address range for frequent collisions
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 40) == 0);
            wr0_en   = $urandom_range(0, 1);
            wr0_addr = AW'($urandom_range(0, 7));
            wr0_data = {$urandom, $urandom};
            wr1_en   = $urandom_range(0, 1);
            wr1_addr = AW'($urandom_range(0, 7));
            wr1_data = {$urandom, $urandom};
            sb_set   = $urandom_range(0, 1);
            sb_addr  = AW'($urandom_range(0, 7));
            set_rd($urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 31), $urandom_range(0, 7));
            tick();
        end
        rst = 0;
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
